// File: rtl/touch_uart_packet_rx_if.sv
// touch_uart_packet_rx_if: report channel from the touch receiver to its consumer.
// Latency: none (wires only).
// Backpressure: plain valid/ready; the source holds pen/x/y stable while pkt_valid is high.
// Signals: pkt_valid, pkt_ready, pkt_pen (1 = pen down), pkt_x[11:0], pkt_y[11:0].
// Modports: master = report source (receiver), slave = report consumer.
interface touch_uart_packet_rx_if;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_pen;
    logic [11:0] pkt_x;
    logic [11:0] pkt_y;

    modport master (
        output pkt_valid,
        output pkt_pen,
        output pkt_x,
        output pkt_y,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  pkt_pen,
        input  pkt_x,
        input  pkt_y,
        output pkt_ready
    );
endinterface

// File: rtl/touch_uart_packet_rx.sv
// touch_uart_packet_rx: 8N1 UART receiver plus decoder for 5-byte touch reports (pen, 12-bit X/Y).
// Latency: pkt_valid rises on the clock edge after the stop-bit sample of the report's last byte.
// Backpressure: one report is held while pkt_ready=0; a report completing meanwhile is dropped and overrun pulses.
// Ports: clk_clk, reset_reset_n (async active-low), touchscreen_rxd (serial in, idle high, async),
//        pkt (touch_uart_packet_rx_if.master: pkt_valid/pkt_ready/pkt_pen/pkt_x/pkt_y),
//        frame_err (1-cycle pulse: bad stop bit or inter-byte timeout), overrun (1-cycle pulse: report dropped).
// Build option: define TOUCH_RX_TIMEOUT_EN to add an inter-byte timeout of TIMEOUT_BITS bit periods.
module touch_uart_packet_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   touchscreen_rxd,
    touch_uart_packet_rx_if.master pkt,
    output logic                   frame_err,
    output logic                   overrun
);
    localparam int            CW      = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // Input synchroniser; rxd_prev is a third stage used only for the
    // falling-edge detect that starts a byte.
    // ------------------------------------------------------------------
    logic rxd_meta;
    logic rxd_sync;
    logic rxd_prev;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= touchscreen_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // ------------------------------------------------------------------
    // UART byte FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    uart_state_t   u_state;
    uart_state_t   u_state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic          wait_high;
    logic          wait_high_nxt;
    logic          byte_done;
    logic          stop_err;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            u_state   <= U_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            wait_high <= 1'b0;
        end else begin
            u_state   <= u_state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            wait_high <= wait_high_nxt;
        end
    end

    always_comb begin
        u_state_nxt   = u_state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        wait_high_nxt = wait_high;
        byte_done     = 1'b0;
        stop_err      = 1'b0;
        case (u_state)
            U_IDLE: begin
                if (rxd_prev && !rxd_sync) begin
                    u_state_nxt = U_START;
                    cnt_nxt     = '0;
                end
            end
            U_START: begin
                if (cnt == HALF_M1) begin
                    // A line already back high at mid start bit is a glitch: drop it quietly.
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    u_state_nxt = rxd_sync ? U_IDLE : U_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            U_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rxd_sync, shreg[7:1]};   // LSB arrives first
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        u_state_nxt = U_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            U_STOP: begin
                if (wait_high) begin
                    // After a framing error, stay here until the line idles so a
                    // long low (break) cannot be mistaken for a new start bit.
                    if (rxd_sync) begin
                        wait_high_nxt = 1'b0;
                        u_state_nxt   = U_IDLE;
                    end
                end else if (cnt == BIT_M1) begin
                    cnt_nxt = '0;
                    if (rxd_sync) begin
                        byte_done   = 1'b1;
                        u_state_nxt = U_IDLE;
                    end else begin
                        stop_err      = 1'b1;
                        wait_high_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: u_state_nxt = U_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Packet assembler
    // ------------------------------------------------------------------
    typedef enum logic {
        A_HUNT,
        A_COLLECT
    } asm_state_t;

    asm_state_t a_state;
    asm_state_t a_state_nxt;
    // idx holds the slot of the next data byte: 0..3 for b1..b4.
    logic [1:0] idx;
    logic [1:0] idx_nxt;
    logic       pen_l;
    logic       pen_l_nxt;
    logic [6:0] b1;
    logic [6:0] b1_nxt;
    logic [4:0] b2;
    logic [4:0] b2_nxt;
    logic [6:0] b3;
    logic [6:0] b3_nxt;
    logic       is_hdr;
    logic       complete;
    logic       tmo_fire;

    assign is_hdr = shreg[7] && (shreg[6:1] == 6'd0);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            a_state <= A_HUNT;
            idx     <= '0;
            pen_l   <= 1'b0;
            b1      <= '0;
            b2      <= '0;
            b3      <= '0;
        end else begin
            a_state <= a_state_nxt;
            idx     <= idx_nxt;
            pen_l   <= pen_l_nxt;
            b1      <= b1_nxt;
            b2      <= b2_nxt;
            b3      <= b3_nxt;
        end
    end

    always_comb begin
        a_state_nxt = a_state;
        idx_nxt     = idx;
        pen_l_nxt   = pen_l;
        b1_nxt      = b1;
        b2_nxt      = b2;
        b3_nxt      = b3;
        complete    = 1'b0;
        if (stop_err || tmo_fire) begin
            a_state_nxt = A_HUNT;
        end else if (byte_done) begin
            case (a_state)
                A_HUNT: begin
                    if (is_hdr) begin
                        pen_l_nxt   = shreg[0];
                        idx_nxt     = '0;
                        a_state_nxt = A_COLLECT;
                    end
                end
                A_COLLECT: begin
                    if (shreg[7]) begin
                        // Unexpected marker byte: restart on a header, otherwise lose sync.
                        if (is_hdr) begin
                            pen_l_nxt = shreg[0];
                            idx_nxt   = '0;
                        end else begin
                            a_state_nxt = A_HUNT;
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                        case (idx)
                            2'd0: b1_nxt = shreg[6:0];
                            2'd1: b2_nxt = shreg[4:0];
                            2'd2: b3_nxt = shreg[6:0];
                            default: begin
                                // b4 is consumed straight from the shifter.
                                complete    = 1'b1;
                                a_state_nxt = A_HUNT;
                            end
                        endcase
                    end
                end
                default: a_state_nxt = A_HUNT;
            endcase
        end
    end

`ifdef TOUCH_RX_TIMEOUT_EN
    // Inter-byte timer: bit periods counted with a per-bit prescaler so both
    // counters stay small. Held at zero outside COLLECT and reloaded by every byte.
    localparam int            TW     = $clog2(TIMEOUT_BITS) + 1;
    localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT_BITS - 1);

    logic [CW-1:0] tmo_cyc;
    logic [TW-1:0] tmo_bits;

    assign tmo_fire = (a_state == A_COLLECT) && !byte_done &&
                      (tmo_cyc == BIT_M1) && (tmo_bits == TMO_M1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tmo_cyc  <= '0;
            tmo_bits <= '0;
        end else if (a_state != A_COLLECT || byte_done || tmo_fire) begin
            tmo_cyc  <= '0;
            tmo_bits <= '0;
        end else if (tmo_cyc == BIT_M1) begin
            tmo_cyc  <= '0;
            tmo_bits <= tmo_bits + 1'b1;
        end else begin
            tmo_cyc <= tmo_cyc + 1'b1;
        end
    end
`else
    // No timer in this build: a partial packet waits for its next byte indefinitely.
    // TIMEOUT_BITS is referenced only so the parameter list is identical in both builds.
    assign tmo_fire = (TIMEOUT_BITS < 0);
`endif

    // ------------------------------------------------------------------
    // Output register and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pkt.pkt_valid <= 1'b0;
            pkt.pkt_pen   <= 1'b0;
            pkt.pkt_x     <= '0;
            pkt.pkt_y     <= '0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_err <= stop_err | tmo_fire;
            overrun   <= 1'b0;
            if (complete) begin
                // A report leaving this cycle frees the register for the new one.
                if (!pkt.pkt_valid || pkt.pkt_ready) begin
                    pkt.pkt_valid <= 1'b1;
                    pkt.pkt_pen   <= pen_l;
                    pkt.pkt_x     <= {b2, b1};
                    pkt.pkt_y     <= {shreg[4:0], b3};
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pkt.pkt_valid && pkt.pkt_ready) begin
                pkt.pkt_valid <= 1'b0;
            end
        end
    end
endmodule
